// File: rtl/ps2_rx_framer_pkg.sv
// Shared PS/2 receive definitions: frame geometry, FSM states and the
// stop-bit outcome priority used by the framer.
package ps2_rx_framer_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    typedef enum logic [1:0] {
        RES_FRAME_ERR,
        RES_PARITY_ERR,
        RES_OVERFLOW,
        RES_WRITE
    } outcome_e;

    // Exactly one outcome per completed frame, highest priority first.
    function automatic outcome_e stop_outcome(input logic stop_bit,
                                              input logic parity_ok,
                                              input logic fifo_full);
        if (!stop_bit)
            return RES_FRAME_ERR;
        else if (!parity_ok)
            return RES_PARITY_ERR;
        else if (fifo_full)
            return RES_OVERFLOW;
        else
            return RES_WRITE;
    endfunction

endpackage

// File: rtl/ps2_rx_framer_if.sv
// Framer-to-FIFO write port: byte, write strobe and the FIFO full flag.
interface ps2_rx_framer_if;
    import ps2_rx_framer_pkg::*;

    logic                     wr_en;
    logic [PS2_DATA_BITS-1:0] data_out;
    logic                     fifo_full;

    modport master (output wr_en, output data_out, input fifo_full);
    modport slave  (input wr_en, input data_out, output fifo_full);

endinterface

// File: rtl/ps2_rx_framer_sync.sv
// Pin synchronisers for the PS/2 clock and data lines plus a registered
// falling-edge detector on the synchronised clock.
module ps2_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic data_sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   fall_q, fall_d;
    logic                   data_q, data_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        fall_d      = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        // Data is registered alongside fall so the pair stays cycle-aligned.
        data_d      = data_sync_q[SYNC_STAGES-1];
    end

    // NOTE: non-blocking assignments for every flop, so all registers update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: reset to 1 matches the idle-high bus, so leaving reset
            // never manufactures a falling edge.
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            data_q      <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            fall_q      <= fall_d;
            data_q      <= data_d;
        end
    end

    assign data_sync = data_q;
    assign fall      = fall_q;

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host frame receiver: deserialises start/8 data/odd parity/
// stop frames and writes good bytes to the FIFO, pulsing on faults.
module ps2_rx_framer
    import ps2_rx_framer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2000,
    parameter int TO_WIDTH    = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    inout  wire                     VPWR,
    inout  wire                     VGND,
    input  logic                    ps2_clk_in,
    input  logic                    ps2_data_in,
    ps2_rx_framer_if.master         fifo,
    output logic                    parity_err,
    output logic                    frame_err,
    output logic                    overflow,
    output logic                    busy
);

    localparam logic [2:0]          LAST_BIT = 3'(PS2_DATA_BITS - 1);
    localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT - 1);

    wire unused_rails = VPWR ^ VGND;

    logic fall;
    logic data_bit;

    ps2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .data_sync   (data_bit),
        .fall        (fall)
    );

    state_e                   state_q, state_d;
    logic [2:0]               bitcnt_q, bitcnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_q, par_d;
    logic [TO_WIDTH-1:0]      to_cnt_q, to_cnt_d;
    logic [PS2_DATA_BITS-1:0] data_out_q, data_out_d;
    logic                     wr_en_q, wr_en_d;
    logic                     parity_err_q, parity_err_d;
    logic                     frame_err_q, frame_err_d;
    logic                     overflow_q, overflow_d;
    logic                     parity_ok;

    assign parity_ok = ^{shift_q, par_q};

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        to_cnt_d     = to_cnt_q;
        data_out_d   = data_out_q;
        wr_en_d      = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overflow_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (fall && !data_bit) begin
                    state_d  = ST_DATA;
                    bitcnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d  = {data_bit, shift_q[PS2_DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == LAST_BIT)
                        state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = data_bit;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    unique case (stop_outcome(data_bit, parity_ok, fifo.fifo_full))
                        RES_FRAME_ERR:  frame_err_d  = 1'b1;
                        RES_PARITY_ERR: parity_err_d = 1'b1;
                        RES_OVERFLOW:   overflow_d   = 1'b1;
                        RES_WRITE: begin
                            wr_en_d    = 1'b1;
                            data_out_d = shift_q;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled partial frame is abandoned; the byte never reaches data_out.
        if (state_q != ST_IDLE) begin
            if (fall) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                state_d     = ST_IDLE;
                to_cnt_d    = '0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            data_out_q   <= '0;
            wr_en_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            data_out_q   <= data_out_d;
            wr_en_q      <= wr_en_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign fifo.wr_en    = wr_en_q;
    assign fifo.data_out = data_out_q;
    assign parity_err    = parity_err_q;
    assign frame_err     = frame_err_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/ps2_rx_framer.md
Name: ps2_rx_framer

Overview:
Upstream stage of the PS/2 receive path. Synchronises the raw PS/2 clock and data pins into the system clock domain and deserialises 11-bit device-to-host frames (start, 8 data bits LSB first, odd parity, stop). Each good byte is pushed into the dual-port FIFO with a single-cycle write strobe. Protocol faults and FIFO overflow are reported as one-cycle pulses.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the pin synchronisers (minimum 2)
TIMEOUT, 2000, system clocks with no PS/2 falling edge before a partial frame is abandoned
TO_WIDTH, 11, counter width; must satisfy 2^TO_WIDTH > TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
VPWR  inout  1  power rail, no logic function
VGND  inout  1  ground rail, no logic function
ps2_clk_in  in  1  raw PS/2 clock pin, asynchronous
ps2_data_in  in  1  raw PS/2 data pin, asynchronous
fifo_full  in  1  full flag from downstream FIFO
wr_en  out  1  one-cycle write strobe to FIFO
data_out  out  8  received byte, valid while wr_en is high and held afterwards
parity_err  out  1  one-cycle pulse: parity check failed
frame_err  out  1  one-cycle pulse: bad stop bit or timeout
overflow  out  1  one-cycle pulse: good byte dropped because FIFO was full
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset and clocking
  - Reset is synchronous, active-high: clk and rst only. No asynchronous reset anywhere.
  - Reset values: synchroniser flops 1 (bus idle-high), state IDLE, data_out 0x00, wr_en/parity_err/frame_err/overflow/busy 0, bit counter 0, timeout counter 0.
  - rst asserted mid-frame discards the partial frame and produces no pulses.
- Edge detection
  - fall is high for exactly one cycle when the synchronised clock is 1 in the previous cycle and 0 in the current cycle.
  - The synchronised data bit is sampled in that same cycle.
  - Pin-to-fall latency: SYNC_STAGES+1 clocks.
- State machine (transitions happen only on fall, except timeout)
  - IDLE: on fall with data=0 (start bit), go to DATA with bitcnt=0. On fall with data=1, stay in IDLE; this is silently ignored and is not an error.
  - DATA: on each fall, shift right with the new bit entering the MSB (LSB-first assembly); bitcnt++. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the bit. parity_ok = XOR(8 data bits, parity bit) == 1. Go to STOP.
  - STOP: on fall, evaluate the frame, go to IDLE. Exactly one outcome fires, in this priority order:
    - stop=0 -> frame_err
    - else !parity_ok -> parity_err
    - else fifo_full -> overflow
    - else wr_en
  - fifo_full is sampled in the stop-bit fall cycle.
- Outputs
  - All pulses (and wr_en) are registered and assert the cycle after the stop-bit fall, for exactly 1 cycle.
  - data_out updates only in the cycle wr_en asserts; otherwise it holds its value.
  - wr_en is never asserted when fifo_full was high at the sample point.
- Timeout
  - Counter clears on every fall and is held at 0 in IDLE.
  - In DATA, PARITY or STOP: if the counter reaches TIMEOUT-1 with no fall, go to IDLE and pulse frame_err the next cycle.
  - The partial byte is discarded and data_out is unchanged.
- Back-to-back frames: a start bit arriving on the first fall after STOP is accepted; no idle gap is required.

Decomposition:
- Shared header ps2_defs: state encodings (IDLE, DATA, PARITY, STOP), PS2_DATA_BITS=8, PS2_FRAME_BITS=11.
- One sub-module ps2_sync: a SYNC_STAGES-deep synchroniser for both pins plus the falling-edge detector. It outputs the synchronised data and fall, with synchronous active-high reset to 1.

Test Plan:
- Valid frame: byte 0x1C with parity=0, stop=1, fifo_full=0 -> single wr_en pulse; data_out=0x1C; no error pulses; busy low after the frame.
- Parity fault: byte 0x1C with parity=1 -> parity_err pulse, no wr_en, data_out keeps its previous value.
- Framing and overflow:
  - stop=0 on byte 0xAA -> frame_err only.
  - Valid 0xF0 (parity=1) with fifo_full=1 -> overflow only, no wr_en, data_out unchanged.
- Timeout: start bit + 3 data bits, then the clock stays high for TIMEOUT cycles -> frame_err one cycle after the count expires and busy=0. A following valid 0xF0 then yields wr_en with data_out=0xF0.
- Back-to-back: 0xAA (parity 1) immediately followed by 0x55 (parity 1) -> two wr_en pulses, data 0xAA then 0x55.
- Reset mid-frame: rst for 1 cycle after 4 data bits -> no pulses, busy=0. A subsequent full 0x1C frame is received correctly.
